prog_loader: RTL and testbench
==============================

Name: prog_loader

Overview:
- Upstream feeder for the processor core. Receives a byte stream over a valid/ready handshake and assembles it into 16-bit instruction words.
- Writes the words into an internal program RAM that replaces the fixed-parameter program ROM. Serves instruction fetches on a combinational read port addressed by the program counter.
- Holds the core in reset (cpu_rstn low) until a complete image is loaded.

Parameters:
- WORDS, 16, number of instruction words in one image; RAM depth. Legal range 2..32.
- ADDR_W, 5, width of the fetch address; matches the program counter width.

Ports:
- clk  input  1  single clock; all state changes on its rising edge.
- rst  input  1  synchronous, active-high reset.
- start  input  1  single-cycle pulse that begins a new image load.
- rx_data  input  8  incoming image byte.
- rx_valid  input  1  rx_data is valid this cycle.
- rx_ready  output  1  loader accepts a byte this cycle; transfer occurs when rx_valid && rx_ready.
- fetch_addr  input  ADDR_W  instruction fetch address from the program counter.
- cell_data  output  16  instruction word at fetch_addr; bits 15:12 register select, 11:8 opcode, 7:0 data.
- cpu_rstn  output  1  active-low reset to the core; high only when an image is loaded.
- busy  output  1  load in progress.
- words_loaded  output  ADDR_W+1  count of words written in the current load.
- load_err  output  1  image rejected; only driven when CHECKSUM_EN is defined, otherwise tied 0.

Behaviour:
- Reset is synchronous and active-high.
  - Reset values: state=IDLE, rx_ready=0, cpu_rstn=0, busy=0, words_loaded=0, load_err=0, byte staging register=0.
  - RAM contents are not reset; they are undefined until the first load.
- States:
  - IDLE: on start, go to LOAD_HI and clear words_loaded.
  - LOAD_HI: rx_ready=1. On handshake, latch rx_data into hi[7:0] and go to LOAD_LO.
  - LOAD_LO: rx_ready=1. On handshake, write {hi, rx_data} to RAM[words_loaded] at that edge and increment words_loaded.
    - If words_loaded was WORDS-1, go to DONE (or CHECK when CHECKSUM_EN is defined).
    - Otherwise return to LOAD_HI.
  - DONE: cpu_rstn=1, rx_ready=0, busy=0. On start, go to LOAD_HI, drop cpu_rstn in the next cycle, and clear words_loaded.
- busy=1 in LOAD_HI, LOAD_LO and CHECK.
- Byte order: high byte first, words at ascending addresses from 0.
- Handshake:
  - rx_ready is a registered state decode, independent of rx_valid.
  - rx_valid without rx_ready has no effect; bytes are never dropped or duplicated.
  - Stalls of any length between bytes are legal.
- start during LOAD_HI, LOAD_LO or CHECK is ignored; a load cannot be aborted except by rst.
- rst mid-load returns to IDLE with cpu_rstn=0. A partial image leaves RAM partially overwritten; the next full load rewrites every word.
- Fetch port:
  - cell_data = RAM[fetch_addr] combinationally when cpu_rstn=1; otherwise 16'h0000.
  - fetch_addr >= WORDS returns 16'h0000.
- Latency: cpu_rstn rises on the first clock after the edge that writes the last word (or that passes the checksum).
- Exactly 2*WORDS bytes are accepted per load (plus 1 when CHECKSUM_EN is defined).

Optional Feature:
- Macro: PROG_LOADER_CHECKSUM_EN.
- Defined:
  - A running XOR of all image bytes is kept and cleared on start.
  - After the last word, state CHECK asserts rx_ready for one extra byte. It must equal the running XOR.
  - Match: go to DONE, load_err=0.
  - Mismatch: go to ERROR. In ERROR, cpu_rstn=0, load_err=1, rx_ready=0; start leaves ERROR for LOAD_HI and clears load_err.
- Not defined: no CHECK or ERROR states, load_err tied 0, no trailing byte.

Decomposition:
- Shared package/include:
  - State encodings (IDLE, LOAD_HI, LOAD_LO, CHECK, DONE, ERROR).
  - The 16-bit instruction field positions (15:12, 11:8, 7:0), shared with the decoder.
- One sub-module: prog_ram, WORDS x 16, one synchronous write port, one combinational read port.

Test Plan:
- Reset then idle: assert rst 2 cycles, hold rx_valid=1 → rx_ready=0, cpu_rstn=0, cell_data=16'h0000, words_loaded=0.
- Full load, WORDS=16: start, stream 32 bytes 0x0C,0x00 … with word 2 = 0x0A,0x05 → cpu_rstn=1 exactly one cycle after the 32nd handshake; fetch_addr=2 gives 16'h0A05, fetch_addr=20 gives 16'h0000.
- Backpressure/stalls: randomly deassert rx_valid between bytes, and pulse start mid-load → same RAM image as the back-to-back case; start ignored; words_loaded steps 0..16.
- Reload and mid-load reset: after DONE, pulse start → cpu_rstn=0 next cycle. Reset after 7 bytes → IDLE, cpu_rstn=0; a fresh full load then succeeds.
- Checksum with PROG_LOADER_CHECKSUM_EN defined:
  - Correct XOR trailer → DONE.
  - Trailer XOR'ed with 0x01 → load_err=1, cpu_rstn=0.
  - Then start → load_err clears.

Source files
------------

// File: rtl/prog_loader_pkg.sv
// Shared loader/decoder definitions: FSM state encoding and instruction word layout.
// Field positions here are the single source of truth for register select, opcode and data.
package prog_loader_pkg;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_LOAD_HI,
    ST_LOAD_LO,
    ST_CHECK,
    ST_DONE,
    ST_ERROR
  } state_t;

  // bits 15:12 register select, 11:8 opcode, 7:0 data
  typedef struct packed {
    logic [3:0] reg_sel;
    logic [3:0] opcode;
    logic [7:0] data;
  } instr_t;

  localparam int INSTR_W = $bits(instr_t);

  function automatic instr_t make_instr(input logic [7:0] hi, input logic [7:0] lo);
    return instr_t'({hi, lo});
  endfunction

endpackage

// File: rtl/prog_loader_if.sv
// Byte stream (valid/ready) and instruction fetch bundle between feeder, loader and core.
// Master drives bytes and fetch address; slave (loader) returns ready and the fetched word.
interface prog_loader_if
  import prog_loader_pkg::*;
#(
  parameter int ADDR_W = 5
);
  logic [7:0]        rx_data;
  logic              rx_valid;
  logic              rx_ready;
  logic [ADDR_W-1:0] fetch_addr;
  instr_t            cell_data;

  modport master (
    output rx_data, rx_valid, fetch_addr,
    input  rx_ready, cell_data
  );

  modport slave (
    input  rx_data, rx_valid, fetch_addr,
    output rx_ready, cell_data
  );
endinterface

// File: rtl/prog_ram.sv
// Program RAM, WORDS x 16: synchronous write, combinational read.
// No reset on contents; out-of-range reads are masked by the caller.
module prog_ram
  import prog_loader_pkg::*;
#(
  parameter int WORDS = 16,
  parameter int IDX_W = 4
) (
  input  logic             clk,
  input  logic             wr_en,
  input  logic [IDX_W-1:0] wr_addr,
  input  instr_t           wr_dat,
  input  logic [IDX_W-1:0] rd_addr,
  output instr_t           rd_dat
);

  instr_t mem [WORDS];

  always_ff @(posedge clk) begin
    if (wr_en) mem[wr_addr] <= wr_dat;
  end

  assign rd_dat = mem[rd_addr];

endmodule

// File: rtl/prog_loader.sv
// Byte-stream program loader: packs hi/lo bytes into RAM words, holds core reset until loaded; cpu_rstn high the cycle after the final accepting edge.
// rx_ready is a registered state decode (never depends on rx_valid); PROG_LOADER_CHECKSUM_EN adds an XOR trailer byte check.
module prog_loader
  import prog_loader_pkg::*;
#(
  parameter int WORDS  = 16,
  parameter int ADDR_W = 5
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              start,
  prog_loader_if.slave      bus,
  output logic              cpu_rstn,
  output logic              busy,
  output logic [ADDR_W:0]   words_loaded,
  output logic              load_err
);

  localparam int              IDX_W     = (WORDS > 1) ? $clog2(WORDS) : 1;
  localparam logic [ADDR_W:0] LAST_WORD = (ADDR_W+1)'(WORDS - 1);
  localparam logic [ADDR_W:0] DEPTH     = (ADDR_W+1)'(WORDS);
  localparam logic [ADDR_W:0] ONE       = (ADDR_W+1)'(1);

  state_t          state;
  logic [7:0]      hi_q;
  logic            rx_ready_q;
  logic            cpu_rstn_q;
  logic            busy_q;
  logic [ADDR_W:0] wcnt_q;
  logic            hs;
  logic            wr_en;
  logic            in_range;
  instr_t          wr_dat;
  instr_t          rd_dat;

`ifdef PROG_LOADER_CHECKSUM_EN
  logic [7:0]      csum_q;
  logic            err_q;
  assign load_err = err_q;
`else
  assign load_err = 1'b0;
`endif

  assign hs       = bus.rx_valid && rx_ready_q;
  assign wr_en    = hs && (state == ST_LOAD_LO);
  assign wr_dat   = make_instr(hi_q, bus.rx_data);
  assign in_range = {1'b0, bus.fetch_addr} < DEPTH;

  prog_ram #(
    .WORDS (WORDS),
    .IDX_W (IDX_W)
  ) u_ram (
    .clk     (clk),
    .wr_en   (wr_en),
    .wr_addr (wcnt_q[IDX_W-1:0]),
    .wr_dat  (wr_dat),
    .rd_addr (bus.fetch_addr[IDX_W-1:0]),
    .rd_dat  (rd_dat)
  );

  assign bus.rx_ready  = rx_ready_q;
  assign bus.cell_data = (cpu_rstn_q && in_range) ? rd_dat : '0;
  assign cpu_rstn      = cpu_rstn_q;
  assign busy          = busy_q;
  assign words_loaded  = wcnt_q;

  // Outputs are registered alongside each transition so they always match the state being entered.
  always_ff @(posedge clk) begin
    if (rst) begin
      state      <= ST_IDLE;
      hi_q       <= '0;
      rx_ready_q <= 1'b0;
      cpu_rstn_q <= 1'b0;
      busy_q     <= 1'b0;
      wcnt_q     <= '0;
`ifdef PROG_LOADER_CHECKSUM_EN
      csum_q     <= '0;
      err_q      <= 1'b0;
`endif
    end else begin
      case (state)
        ST_IDLE, ST_DONE, ST_ERROR: begin
          if (start) begin
            state      <= ST_LOAD_HI;
            rx_ready_q <= 1'b1;
            busy_q     <= 1'b1;
            cpu_rstn_q <= 1'b0;
            wcnt_q     <= '0;
`ifdef PROG_LOADER_CHECKSUM_EN
            csum_q     <= '0;
            err_q      <= 1'b0;
`endif
          end
        end

        ST_LOAD_HI: begin
          if (hs) begin
            hi_q  <= bus.rx_data;
            state <= ST_LOAD_LO;
`ifdef PROG_LOADER_CHECKSUM_EN
            csum_q <= csum_q ^ bus.rx_data;
`endif
          end
        end

        ST_LOAD_LO: begin
          if (hs) begin
            wcnt_q <= wcnt_q + ONE;
`ifdef PROG_LOADER_CHECKSUM_EN
            csum_q <= csum_q ^ bus.rx_data;
`endif
            if (wcnt_q == LAST_WORD) begin
`ifdef PROG_LOADER_CHECKSUM_EN
              state <= ST_CHECK;
`else
              state      <= ST_DONE;
              rx_ready_q <= 1'b0;
              busy_q     <= 1'b0;
              cpu_rstn_q <= 1'b1;
`endif
            end else begin
              state <= ST_LOAD_HI;
            end
          end
        end

`ifdef PROG_LOADER_CHECKSUM_EN
        ST_CHECK: begin
          if (hs) begin
            rx_ready_q <= 1'b0;
            busy_q     <= 1'b0;
            if (bus.rx_data == csum_q) begin
              state      <= ST_DONE;
              cpu_rstn_q <= 1'b1;
            end else begin
              state <= ST_ERROR;
              err_q <= 1'b1;
            end
          end
        end
`endif

        default: begin
          state      <= ST_IDLE;
          rx_ready_q <= 1'b0;
          busy_q     <= 1'b0;
          cpu_rstn_q <= 1'b0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_prog_loader.sv
// Randomized self-checking bench for prog_loader against an image-level reference model.
// Covers reset/idle, directed and random loads with stalls, ignored start, reload, mid-load reset, checksum.
module tb_prog_loader;
  import prog_loader_pkg::*;

  localparam int W  = 16;
  localparam int AW = 5;
`ifdef PROG_LOADER_CHECKSUM_EN
  localparam int NB = 2 * W + 1;
`else
  localparam int NB = 2 * W;
`endif

  logic          clk = 1'b0;
  logic          rst;
  logic          start;
  logic          cpu_rstn;
  logic          busy;
  logic [AW:0]   words_loaded;
  logic          load_err;

  prog_loader_if #(.ADDR_W(AW)) bus ();

  prog_loader #(.WORDS(W), .ADDR_W(AW)) dut (
    .clk          (clk),
    .rst          (rst),
    .start        (start),
    .bus          (bus),
    .cpu_rstn     (cpu_rstn),
    .busy         (busy),
    .words_loaded (words_loaded),
    .load_err     (load_err)
  );

  always #5 clk = ~clk;

  int          n_vec = 0;
  int          n_err = 0;
  logic [7:0]  img [0:2*W];
  logic [15:0] model_mem [W];
  bit          model_loaded = 0;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_vec++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    end
  endtask

  // Image builders; the last slot always holds the XOR of all image bytes.
  task automatic set_trailer(input bit bad);
    logic [7:0] x = 8'h00;
    for (int i = 0; i < 2 * W; i++) x ^= img[i];
    img[2*W] = bad ? (x ^ 8'h01) : x;
  endtask

  task automatic fill_directed();
    for (int w = 0; w < W; w++) begin
      img[2*w]   = (w == 2) ? 8'h0A : 8'h0C;
      img[2*w+1] = (w == 2) ? 8'h05 : 8'h00;
    end
    set_trailer(0);
  endtask

  task automatic fill_random();
    for (int i = 0; i < 2 * W; i++) img[i] = 8'($urandom);
    set_trailer(0);
  endtask

  task automatic check_fetch(input string tag);
    logic [15:0] e;
    for (int a = 0; a < 32; a++) begin
      bus.fetch_addr = AW'(a);
      #1;
      e = (model_loaded && a < W) ? model_mem[a] : 16'h0000;
      chk($sformatf("%s_fetch[%0d]", tag, a), 32'(bus.cell_data), 32'(e));
    end
  endtask

  task automatic pulse_start();
    @(negedge clk);
    start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    model_loaded = 0;
    chk("start_cpu_rstn", 32'(cpu_rstn), 32'd0);
    chk("start_busy", 32'(busy), 32'd1);
    chk("start_rx_ready", 32'(bus.rx_ready), 32'd1);
    chk("start_words", 32'(words_loaded), 32'd0);
    chk("start_load_err", 32'(load_err), 32'd0);
  endtask

  // Returns just after the edge on which the byte was transferred.
  task automatic send_byte(input logic [7:0] b, input int stall, input bit poke_start);
    int t;
    for (int i = 0; i < stall; i++) begin
      @(negedge clk);
      bus.rx_valid = 1'b0;
      bus.rx_data  = 8'($urandom);
      start        = poke_start && ($urandom_range(0, 2) == 0);
    end
    @(negedge clk);
    start        = 1'b0;
    bus.rx_valid = 1'b1;
    bus.rx_data  = b;
    t = 0;
    while (bus.rx_ready !== 1'b1 && t < 50) begin
      @(negedge clk);
      t++;
    end
    if (t >= 50) begin
      chk("rx_ready_timeout", 32'd0, 32'd1);
      bus.rx_valid = 1'b0;
    end
    @(posedge clk);
    #1;
  endtask

  task automatic load_image(input int nbytes, input int max_stall, input bit poke, input bit exp_ok);
    bit last;
    pulse_start();
    for (int k = 0; k < nbytes; k++) begin
      send_byte(img[k], (max_stall > 0) ? $urandom_range(0, max_stall) : 0, poke);
      last = (k == nbytes - 1);
      chk($sformatf("words_after_byte%0d", k), 32'(words_loaded), 32'((k + 1) / 2));
      chk($sformatf("cpu_rstn_after_byte%0d", k), 32'(cpu_rstn), 32'(last && exp_ok));
      chk($sformatf("busy_after_byte%0d", k), 32'(busy), 32'(!last));
    end
    // rx_valid lingers for half a cycle with rx_ready low: must have no effect.
    @(negedge clk);
    bus.rx_valid = 1'b0;
    chk("rx_ready_after_load", 32'(bus.rx_ready), 32'd0);
`ifdef PROG_LOADER_CHECKSUM_EN
    chk("load_err_after_load", 32'(load_err), 32'(!exp_ok));
`endif
    if (exp_ok) begin
      for (int w = 0; w < W; w++) model_mem[w] = {img[2*w], img[2*w+1]};
      model_loaded = 1;
    end
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1, "watchdog expired");
  end

  initial begin
    rst            = 1'b1;
    start          = 1'b0;
    bus.rx_valid   = 1'b1;
    bus.rx_data    = 8'h5A;
    bus.fetch_addr = AW'(2);

    // Reset and idle
    repeat (2) @(posedge clk);
    #1;
    chk("rst_rx_ready", 32'(bus.rx_ready), 32'd0);
    chk("rst_cpu_rstn", 32'(cpu_rstn), 32'd0);
    chk("rst_busy", 32'(busy), 32'd0);
    chk("rst_words", 32'(words_loaded), 32'd0);
    chk("rst_load_err", 32'(load_err), 32'd0);
    chk("rst_cell_data", 32'(bus.cell_data), 32'd0);
    @(negedge clk);
    rst = 1'b0;
    repeat (3) @(negedge clk);
    chk("idle_rx_ready", 32'(bus.rx_ready), 32'd0);
    chk("idle_words", 32'(words_loaded), 32'd0);
    chk("idle_cpu_rstn", 32'(cpu_rstn), 32'd0);
    bus.rx_valid = 1'b0;

    // Directed back-to-back image
    fill_directed();
    load_image(NB, 0, 0, 1);
    bus.fetch_addr = AW'(2);
    #1 chk("word2", 32'(bus.cell_data), 32'h0A05);
    bus.fetch_addr = AW'(20);
    #1 chk("addr20", 32'(bus.cell_data), 32'h0000);
    check_fetch("directed");

    // Random images with stalls and ignored mid-load start pulses
    for (int r = 0; r < 3; r++) begin
      fill_random();
      load_image(NB, 4, 1, 1);
      check_fetch($sformatf("rand%0d", r));
    end

    // Mid-load reset, then a fresh full load
    fill_random();
    pulse_start();
    for (int k = 0; k < 7; k++) send_byte(img[k], $urandom_range(0, 2), 0);
    @(negedge clk);
    bus.rx_valid = 1'b0;
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    chk("midrst_rx_ready", 32'(bus.rx_ready), 32'd0);
    chk("midrst_cpu_rstn", 32'(cpu_rstn), 32'd0);
    chk("midrst_busy", 32'(busy), 32'd0);
    chk("midrst_words", 32'(words_loaded), 32'd0);
    check_fetch("midrst");
    fill_random();
    load_image(NB, 3, 0, 1);
    check_fetch("after_midrst");

`ifdef PROG_LOADER_CHECKSUM_EN
    // Bad trailer rejected, then start clears the error and a good image loads
    fill_random();
    set_trailer(1);
    load_image(NB, 2, 0, 0);
    check_fetch("bad_csum");
    fill_random();
    load_image(NB, 2, 0, 1);
    check_fetch("good_csum");
`endif

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
